// File: rtl/if_pc_sequencer.sv
// Instruction-fetch PC sequencer: issues one fetch at a time, holds the fetched
// word until downstream accepts it, and handles redirects and illegal targets.
module if_pc_sequencer #(
  parameter int unsigned        XLEN         = 32,
  parameter int unsigned        IF_INC       = 4,
  parameter logic [XLEN-1:0]    IF_BASE_ADDR = 32'h1000_0000,
  parameter logic [XLEN-1:0]    IF_MAX_ADDR  = 32'h1000_3FFF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr,
  output logic [31:0]     fetch_cnt
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [XLEN-1:0] LP_LAST = IF_MAX_ADDR - XLEN'(3);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_req;
  logic            r_pend_vld;
  logic [XLEN-1:0] r_pend_addr;
  logic            r_valid;
  logic [XLEN-1:0] r_data;
  logic [XLEN-1:0] r_ipc;
  logic [XLEN-1:0] r_fault_addr;
  logic [31:0]     r_cnt;

  logic            w_legal;
  logic            w_ack;
  logic            w_xfer;
  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_seq;

  always_comb begin
    w_legal = (redirect_addr[1:0] == 2'b00) &&
              (redirect_addr >= IF_BASE_ADDR) && (redirect_addr <= LP_LAST);
    // An ack with no request outstanding (e.g. straggling across reset) is ignored.
    w_ack   = r_req && mem_ack;
    w_xfer  = r_valid && instr_ready;
    w_sum   = {1'b0, r_pc} + (XLEN+1)'(IF_INC);
    w_seq   = (w_sum > {1'b0, LP_LAST}) ? IF_BASE_ADDR : w_sum[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= IF_BASE_ADDR;
      r_req        <= 1'b0;
      r_pend_vld   <= 1'b0;
      r_pend_addr  <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_ipc        <= '0;
      r_fault_addr <= '0;
      r_cnt        <= '0;
    end else begin
      if (w_xfer) begin
        r_cnt <= r_cnt + 32'd1;
      end
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            // Only reachable right after reset: no request in flight yet.
            if (redirect && !w_legal) begin
              r_state      <= S_FAULT;
              r_fault_addr <= redirect_addr;
            end else begin
              if (redirect) begin
                r_pc <= redirect_addr;
              end
              r_req <= 1'b1;
            end
          end else if (redirect && !w_legal) begin
            r_state      <= S_FAULT;
            r_fault_addr <= redirect_addr;
            r_pend_vld   <= 1'b0;
            if (w_ack) begin
              r_req <= 1'b0;
            end
          end else if (redirect) begin
            if (w_ack) begin
              r_pc       <= redirect_addr;
              r_pend_vld <= 1'b0;
            end else begin
              r_pend_vld  <= 1'b1;
              r_pend_addr <= redirect_addr;
            end
          end else if (w_ack) begin
            if (r_pend_vld) begin
              r_pc       <= r_pend_addr;
              r_pend_vld <= 1'b0;
            end else begin
              r_data  <= mem_rdata;
              r_ipc   <= r_pc;
              r_valid <= 1'b1;
              r_req   <= 1'b0;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            r_valid <= 1'b0;
            if (w_legal) begin
              r_state <= S_FETCH;
              r_pc    <= redirect_addr;
              r_req   <= 1'b1;
            end else begin
              r_state      <= S_FAULT;
              r_fault_addr <= redirect_addr;
            end
          end else if (w_xfer) begin
            r_valid <= 1'b0;
            r_state <= S_FETCH;
            r_pc    <= w_seq;
            r_req   <= 1'b1;
          end
        end
        S_FAULT: begin
          if (w_ack) begin
            r_req <= 1'b0;
          end
          if (redirect && w_legal) begin
            r_state <= S_FETCH;
            // A request still in flight must complete first, so park the target.
            if (r_req && !w_ack) begin
              r_pend_vld  <= 1'b1;
              r_pend_addr <= redirect_addr;
            end else begin
              r_pc  <= redirect_addr;
              r_req <= 1'b1;
            end
          end else if (redirect) begin
            r_fault_addr <= redirect_addr;
          end
        end
        default: begin
          r_state <= S_FETCH;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_req     = r_req;
    mem_addr    = r_pc;
    instr_valid = r_valid;
    instr_data  = r_data;
    instr_pc    = r_ipc;
    fault       = (r_state == S_FAULT);
    fault_addr  = r_fault_addr;
    fetch_cnt   = r_cnt;
  end

endmodule

// File: tb/tb_if_pc_sequencer.sv
// Directed bench for if_pc_sequencer: per-cycle vector table plus a hand-written
// multi-transfer sequence with variable ack latency.
module tb_if_pc_sequencer;

  localparam logic [31:0] B = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_cnt;

  int unsigned n_checks;
  int unsigned n_errors;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] raddr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_data;
    logic [31:0] e_pc;
    logic        e_fault;
    logic [31:0] e_faddr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  if_pc_sequencer #(
    .XLEN(32),
    .IF_INC(4),
    .IF_BASE_ADDR(32'h1000_0000),
    .IF_MAX_ADDR(32'h1000_3FFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .fault(fault),
    .fault_addr(fault_addr),
    .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic a, input logic [31:0] rd,
                     input logic rdy, input logic rx, input logic [31:0] ra,
                     input logic eq, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ed, input logic [31:0] ep, input logic ef,
                     input logic [31:0] efa, input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.ack = a; v.rdata = rd; v.ready = rdy; v.redir = rx; v.raddr = ra;
    v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_data = ed; v.e_pc = ep;
    v.e_fault = ef; v.e_faddr = efa; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_addr = '0;
    n_checks = 0; n_errors = 0;

    //   rst ack rdata         rdy rx raddr          req addr          v data          pc            flt faddr          cnt
    add(1, 0, 32'h0,         0, 0, 32'h0,          0, B,             0, 32'h0,       32'h0,        0, 32'h0,          0); // 0
    add(1, 0, 32'h0,         0, 0, 32'h0,          0, B,             0, 32'h0,       32'h0,        0, 32'h0,          0);
    add(0, 0, 32'h0,         0, 0, 32'h0,          1, B,             0, 32'h0,       32'h0,        0, 32'h0,          0);
    add(0, 0, 32'h0,         0, 0, 32'h0,          1, B,             0, 32'h0,       32'h0,        0, 32'h0,          0);
    add(0, 1, 32'hA0,        1, 0, 32'h0,          0, B,             1, 32'hA0,      B,            0, 32'h0,          0); // 4
    add(0, 0, 32'h0,         1, 0, 32'h0,          1, B+4,           0, 32'hA0,      B,            0, 32'h0,          1);
    add(0, 0, 32'h0,         1, 0, 32'h0,          1, B+4,           0, 32'hA0,      B,            0, 32'h0,          1);
    add(0, 1, 32'hA1,        1, 0, 32'h0,          0, B+4,           1, 32'hA1,      B+4,          0, 32'h0,          1);
    add(0, 0, 32'h0,         1, 0, 32'h0,          1, B+8,           0, 32'hA1,      B+4,          0, 32'h0,          2); // 8
    add(0, 0, 32'h0,         1, 0, 32'h0,          1, B+8,           0, 32'hA1,      B+4,          0, 32'h0,          2);
    add(0, 1, 32'hA2,        1, 0, 32'h0,          0, B+8,           1, 32'hA2,      B+8,          0, 32'h0,          2);
    add(0, 0, 32'h0,         1, 0, 32'h0,          1, B+12,          0, 32'hA2,      B+8,          0, 32'h0,          3);
    add(0, 0, 32'h0,         0, 1, B+32'h100,      1, B+12,          0, 32'hA2,      B+8,          0, 32'h0,          3); // 12
    add(0, 1, 32'hA3,        0, 0, 32'h0,          1, B+32'h100,     0, 32'hA2,      B+8,          0, 32'h0,          3);
    add(0, 1, 32'hA4,        0, 0, 32'h0,          0, B+32'h100,     1, 32'hA4,      B+32'h100,    0, 32'h0,          3);
    for (int i = 0; i < 5; i++)
      add(0, 0, 32'h0,       0, 0, 32'h0,          0, B+32'h100,     1, 32'hA4,      B+32'h100,    0, 32'h0,          3); // 15-19
    add(0, 0, 32'h0,         1, 1, B+32'h3FFC,     1, B+32'h3FFC,    0, 32'hA4,      B+32'h100,    0, 32'h0,          4); // 20
    add(0, 1, 32'hA5,        0, 0, 32'h0,          0, B+32'h3FFC,    1, 32'hA5,      B+32'h3FFC,   0, 32'h0,          4);
    add(0, 0, 32'h0,         1, 0, 32'h0,          1, B,             0, 32'hA5,      B+32'h3FFC,   0, 32'h0,          5);
    add(0, 1, 32'hA6,        0, 1, B+32'h40,       1, B+32'h40,      0, 32'hA5,      B+32'h3FFC,   0, 32'h0,          5);
    add(0, 1, 32'hA7,        0, 0, 32'h0,          0, B+32'h40,      1, 32'hA7,      B+32'h40,     0, 32'h0,          5); // 24
    add(0, 0, 32'h0,         0, 1, B+32'h102,      0, B+32'h40,      0, 32'hA7,      B+32'h40,     1, B+32'h102,      5);
    add(0, 0, 32'h0,         0, 1, 32'h2000_0000,  0, B+32'h40,      0, 32'hA7,      B+32'h40,     1, 32'h2000_0000,  5);
    add(0, 0, 32'h0,         0, 1, B+32'h10,       1, B+32'h10,      0, 32'hA7,      B+32'h40,     0, 32'h2000_0000,  5);
    add(0, 1, 32'hA8,        0, 0, 32'h0,          0, B+32'h10,      1, 32'hA8,      B+32'h10,     0, 32'h2000_0000,  5); // 28
    add(0, 0, 32'h0,         1, 0, 32'h0,          1, B+32'h14,      0, 32'hA8,      B+32'h10,     0, 32'h2000_0000,  6);
    add(0, 0, 32'h0,         0, 1, 32'h0FFF_FFFC,  1, B+32'h14,      0, 32'hA8,      B+32'h10,     1, 32'h0FFF_FFFC,  6);
    add(0, 1, 32'hA9,        0, 0, 32'h0,          0, B+32'h14,      0, 32'hA8,      B+32'h10,     1, 32'h0FFF_FFFC,  6);
    add(0, 0, 32'h0,         0, 1, B+32'h20,       1, B+32'h20,      0, 32'hA8,      B+32'h10,     0, 32'h0FFF_FFFC,  6); // 32
    add(0, 0, 32'h0,         0, 1, B+32'h30,       1, B+32'h20,      0, 32'hA8,      B+32'h10,     0, 32'h0FFF_FFFC,  6);
    add(0, 0, 32'h0,         0, 1, B+32'h50,       1, B+32'h20,      0, 32'hA8,      B+32'h10,     0, 32'h0FFF_FFFC,  6);
    add(0, 1, 32'hAA,        0, 0, 32'h0,          1, B+32'h50,      0, 32'hA8,      B+32'h10,     0, 32'h0FFF_FFFC,  6);
    add(0, 1, 32'hAB,        0, 0, 32'h0,          0, B+32'h50,      1, 32'hAB,      B+32'h50,     0, 32'h0FFF_FFFC,  6); // 36
    add(0, 0, 32'h0,         1, 0, 32'h0,          1, B+32'h54,      0, 32'hAB,      B+32'h50,     0, 32'h0FFF_FFFC,  7);
    add(1, 0, 32'h0,         0, 0, 32'h0,          0, B,             0, 32'h0,       32'h0,        0, 32'h0,          0);
    add(1, 1, 32'hEE,        0, 0, 32'h0,          0, B,             0, 32'h0,       32'h0,        0, 32'h0,          0);
    add(0, 1, 32'hEF,        0, 0, 32'h0,          1, B,             0, 32'h0,       32'h0,        0, 32'h0,          0); // 40
    add(0, 1, 32'hAC,        0, 0, 32'h0,          0, B,             1, 32'hAC,      B,            0, 32'h0,          0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
      instr_ready = vecs[i].ready; redirect = vecs[i].redir; redirect_addr = vecs[i].raddr;
      @(posedge clk);
      #1;
      check($sformatf("v%0d mem_req", i),     {31'd0, mem_req},     {31'd0, vecs[i].e_req});
      check($sformatf("v%0d mem_addr", i),    mem_addr,             vecs[i].e_addr);
      check($sformatf("v%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d instr_data", i),  instr_data,           vecs[i].e_data);
      check($sformatf("v%0d instr_pc", i),    instr_pc,             vecs[i].e_pc);
      check($sformatf("v%0d fault", i),       {31'd0, fault},       {31'd0, vecs[i].e_fault});
      check($sformatf("v%0d fault_addr", i),  fault_addr,           vecs[i].e_faddr);
      check($sformatf("v%0d fetch_cnt", i),   fetch_cnt,            vecs[i].e_cnt);
    end

    // Three sequential transfers with growing ack latency, bounded waits throughout.
    for (int k = 0; k < 3; k++) begin
      logic got;
      @(negedge clk);
      mem_ack = 1'b0; instr_ready = 1'b1; redirect = 1'b0;
      @(negedge clk);
      instr_ready = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 4 && !got; c++) begin
        if (mem_req) got = 1'b1;
        else @(negedge clk);
      end
      check($sformatf("seq%0d req_seen", k), {31'd0, got}, 32'd1);
      check($sformatf("seq%0d mem_addr", k), mem_addr, B + 32'(4 * (k + 1)));
      repeat (k + 1) @(negedge clk);
      check($sformatf("seq%0d req_held", k), {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'hC0 + 32'(k);
      @(negedge clk);
      mem_ack = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 4 && !got; c++) begin
        if (instr_valid) got = 1'b1;
        else @(negedge clk);
      end
      check($sformatf("seq%0d valid_seen", k), {31'd0, got}, 32'd1);
      check($sformatf("seq%0d instr_data", k), instr_data, 32'hC0 + 32'(k));
      check($sformatf("seq%0d instr_pc", k), instr_pc, B + 32'(4 * (k + 1)));
    end
    check("seq fetch_cnt", fetch_cnt, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
